// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round constants, S-box tables, GF(2^8) helpers
// and the decryptor FSM encoding. State vectors are [0:127], byte0 = [0:7], column-major.
package aes_pkg;

  localparam int unsigned NR = 10;
  localparam int unsigned NK = 4;

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Indexed by round number 1..10; unused slots are zero.
  localparam logic [0:127] RCON = 128'h0001020408102040801b360000000000;

  typedef enum logic [2:0] {
    S_IDLE, S_KEY_EXP, S_INIT_ARK, S_ROUND, S_FINAL, S_DONE
  } dec_state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    return RCON[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[8*(r+4*c) +: 8] = s[8*(r+4*((c+4-r)%4)) +: 8];
    return o;
  endfunction

  function automatic logic [0:127] inv_sub_bytes(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++)
      o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c +: 8]    = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[32*c+8 +: 8]  = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[32*c+16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[32*c+24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One AES-128 key-schedule step: (previous round key, rcon) -> next round key.
// Purely combinational; shared with the encryptor's key generation.
module aes_key_expand_step
  import aes_pkg::*;
(
  input  logic [0:127] i_prev_key,
  input  logic [7:0]   i_rcon,
  output logic [0:127] o_next_key
);

  logic [0:31] w3, rot, temp, n0, n1, n2, n3;

  always_comb begin
    w3   = i_prev_key[96:127];
    rot  = {w3[8:31], w3[0:7]};
    temp = {sbox(rot[0:7]) ^ i_rcon, sbox(rot[8:15]), sbox(rot[16:23]), sbox(rot[24:31])};
    n0   = i_prev_key[0:31]  ^ temp;
    n1   = i_prev_key[32:63] ^ n0;
    n2   = i_prev_key[64:95] ^ n1;
    n3   = w3 ^ n2;
    o_next_key = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_decrypt.sv
// Iterative AES-128 inverse cipher, one round per clock, full key schedule stored.
// Optional AES_DEC_KEY_CACHE_EN skips key expansion when the key matches the last one expanded.
module aes_decrypt
  import aes_pkg::*;
(
  input  logic         i_clock,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [0:127] i_cipher,
  input  logic [0:127] i_key,
  output logic [0:127] o_plain,
  output logic         o_busy,
  output logic         o_is_done
);

  localparam logic [3:0] LAST_RK = 4'(NR);

  dec_state_t   r_fsm, fsm_next;
  logic [3:0]   r_ctr;
  logic [0:127] r_state;
  logic [0:127] rk [0:NR];

  logic         accept, cache_hit;
  logic [0:127] key_prev, key_next, isb, round_out, final_out;

  assign accept = i_start && (r_fsm == S_IDLE || r_fsm == S_DONE);

`ifdef AES_DEC_KEY_CACHE_EN
  logic         r_key_valid;
  logic [0:127] r_cached_key;
  assign cache_hit = r_key_valid && (i_key == r_cached_key);
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    key_prev  = rk[r_ctr - 4'd1];
    isb       = inv_sub_bytes(inv_shift_rows(r_state));
    round_out = inv_mix_columns(isb ^ rk[r_ctr]);
    final_out = isb ^ rk[0];
  end

  aes_key_expand_step u_key_step (
    .i_prev_key (key_prev),
    .i_rcon     (rcon(r_ctr)),
    .o_next_key (key_next)
  );

  always_comb begin
    fsm_next = r_fsm;
    case (r_fsm)
      S_IDLE, S_DONE: if (i_start) fsm_next = cache_hit ? S_INIT_ARK : S_KEY_EXP;
      S_KEY_EXP:      if (r_ctr == LAST_RK) fsm_next = S_INIT_ARK;
      S_INIT_ARK:     fsm_next = S_ROUND;
      S_ROUND:        if (r_ctr == 4'd1) fsm_next = S_FINAL;
      S_FINAL:        fsm_next = S_DONE;
      default:        fsm_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_rst) r_fsm <= S_IDLE;
    else       r_fsm <= fsm_next;
  end

  // Key store carries no reset; its contents are meaningless until expansion completes.
  always_ff @(posedge i_clock) begin
    if (accept)                   rk[0]     <= i_key;
    else if (r_fsm == S_KEY_EXP)  rk[r_ctr] <= key_next;
  end

  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_ctr     <= '0;
      r_state   <= '0;
      o_plain   <= '0;
      o_busy    <= 1'b0;
      o_is_done <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
      r_key_valid  <= 1'b0;
      r_cached_key <= '0;
`endif
    end else begin
      case (r_fsm)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state   <= i_cipher;
            r_ctr     <= 4'd1;
            o_busy    <= 1'b1;
            o_is_done <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
            if (!cache_hit) r_key_valid <= 1'b0;
`endif
          end
        end
        S_KEY_EXP: begin
          r_ctr <= r_ctr + 4'd1;
`ifdef AES_DEC_KEY_CACHE_EN
          if (r_ctr == LAST_RK) begin
            r_key_valid  <= 1'b1;
            r_cached_key <= rk[0];
          end
`endif
        end
        S_INIT_ARK: begin
          r_state <= r_state ^ rk[NR];
          r_ctr   <= LAST_RK - 4'd1;
        end
        S_ROUND: begin
          r_state <= round_out;
          r_ctr   <= r_ctr - 4'd1;
        end
        S_FINAL: begin
          o_plain   <= final_out;
          o_busy    <= 1'b0;
          o_is_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/aes_decrypt.md
Name: aes_decrypt

Overview:
- Iterative AES-128 decryption core (FIPS-197 inverse cipher). It is the receive-side counterpart to the team's AES-128 encryption top.
- Accepts a 128-bit ciphertext and a 128-bit cipher key and produces the 128-bit plaintext, one round per clock.
- Expands the full key schedule into an internal 11-entry round-key store, then applies the rounds in reverse key order.
- Sits beside the encryptor in the crypto datapath, wrapped by the same host-side controller.

Parameters:
- None. AES-128 only; Nr=10 is a package constant.

Ports:
- i_clock    input   1    single clock, all logic posedge
- i_rst      input   1    reset, synchronous, active-high
- i_start    input   1    one-cycle request; sampled only in IDLE or DONE
- i_cipher   input   128  ciphertext, [0:127], byte0=[0:7], column-major state
- i_key      input   128  cipher key, same bit order
- o_plain    output  128  plaintext, registered; valid while o_is_done=1
- o_busy     output  1    high from accepted start until DONE entered
- o_is_done  output  1    level; high in DONE, cleared on next accepted start or reset

Behaviour:
- Reset values: o_plain=0, o_busy=0, o_is_done=0, FSM=IDLE, round counter=0, key store contents don't-care. i_rst wins over every other event.
- Reset mid-operation aborts immediately: IDLE next cycle, outputs zeroed, no partial result exposed.
- IDLE or DONE with i_start=1: latch i_cipher into r_state, latch i_key into rk[0], set ctr=1, go KEY_EXP. o_busy=1 and o_is_done=0 are registered the same edge.
- KEY_EXP (10 cycles): rk[ctr] = key_step(rk[ctr-1], rcon[ctr]); ctr++. After rk[10] is written, go INIT_ARK.
- INIT_ARK (1 cycle): r_state ^= rk[10]; ctr=9; go ROUND.
- ROUND (9 cycles): r_state = InvMixColumns(InvSubBytes(InvShiftRows(r_state)) ^ rk[ctr]); ctr--. The ctr=1 iteration is the last ROUND; then go FINAL.
- FINAL (1 cycle): o_plain = InvSubBytes(InvShiftRows(r_state)) ^ rk[0]; go DONE. o_is_done=1 and o_busy=0 are registered the same edge.
- DONE: hold o_plain and o_is_done until a new start or reset. There is no self-return to IDLE.
- Latency: start sampled at edge N; o_is_done high after edge N+21.
- i_start while busy (KEY_EXP/INIT_ARK/ROUND/FINAL) is ignored. Changes on i_cipher/i_key after acceptance have no effect.
- o_plain changes only at FINAL and reset. Intermediate state is never visible on it.
- All GF(2^8) arithmetic: reduction polynomial 0x11B; InvMixColumns coefficients {0e,0b,0d,09}.

Optional Feature:
- Macro AES_DEC_KEY_CACHE_EN.
- Defined: a key-valid flag plus a 128-bit copy of the last expanded key are kept. On an accepted start with i_key equal to the cached key and valid=1, KEY_EXP is skipped and the FSM goes straight to INIT_ARK; latency becomes start edge N -> o_is_done after edge N+11.
- Defined, cache invalidation: valid clears on reset, and is set when KEY_EXP completes. An abort mid-KEY_EXP (reset) leaves valid=0.
- Not defined: every start runs the full 10-cycle expansion; there is no cache register or comparator.

Decomposition:
- Shared package aes_pkg:
  - constants NR=10, NK=4
  - forward S-box and inverse S-box tables
  - rcon table
  - functions xtime, gf_mul, inv_shift_rows, inv_sub_bytes, inv_mix_columns
  - FSM state encodings for this block
- The encryptor migrates to the same S-box/rcon sources.
- One natural sub-module: aes_key_expand_step. It is combinational, computing (prev_key, rcon) -> next_key, and is reused by encryptor key generation.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, cipher 3925841d02dc09fbdc118597196a0b32 -> o_plain 3243f6a8885a308d313198a2e0370734; o_is_done rises exactly 21 cycles after start.
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, cipher 69c4e0d86a7b0430d8cdb78070b4c55a -> o_plain 00112233445566778899aabbccddeeff.
- Start pulse at cycles 5 and 12 of a run with different inputs -> second start ignored; result matches the first vector; o_busy stays high throughout.
- i_rst asserted during ROUND (cycle 15) -> next cycle o_busy=0, o_is_done=0, o_plain=0. A fresh start then yields the correct App. B result.
- Back-to-back: start again in DONE with the C.1 vector -> o_is_done drops the next cycle; the new result is correct; o_plain holds the old value until FINAL.
- AES_DEC_KEY_CACHE_EN: two consecutive runs with the same key -> the second has 11-cycle latency. A third run with a changed key -> 21 cycles and a correct result.
